// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keying path.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_LGAP,
    ST_WSP
  } state_t;

  localparam logic [5:0] CODE_SPACE = 6'd36;
  localparam logic [5:0] CODE_MAX   = 6'd36;

  localparam logic [2:0] DOT_U  = 3'd1;
  localparam logic [2:0] DASH_U = 3'd3;
  localparam logic [2:0] GAP_U  = 3'd1;
  localparam logic [2:0] LG_U   = 3'd3;
  localparam logic [2:0] WSP_U  = 3'd4;

  // pat holds the first element in its MSB; 1 = dash
  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [4:0] pat;
  } morse_sym_t;

endpackage

// File: rtl/morse_code_rom.sv
// Character code (A-Z, 0-9) to Morse element length/pattern lookup.
module morse_code_rom
  import morse_pkg::*;
(
  input  logic [5:0] code_i,
  output morse_sym_t sym_o
);

  logic [7:0] lp;

  always_comb begin
    lp = '0;
    case (code_i)
      6'd0:  lp = {3'd2, 5'b01000}; // A
      6'd1:  lp = {3'd4, 5'b10000}; // B
      6'd2:  lp = {3'd4, 5'b10100}; // C
      6'd3:  lp = {3'd3, 5'b10000}; // D
      6'd4:  lp = {3'd1, 5'b00000}; // E
      6'd5:  lp = {3'd4, 5'b00100}; // F
      6'd6:  lp = {3'd3, 5'b11000}; // G
      6'd7:  lp = {3'd4, 5'b00000}; // H
      6'd8:  lp = {3'd2, 5'b00000}; // I
      6'd9:  lp = {3'd4, 5'b01110}; // J
      6'd10: lp = {3'd3, 5'b10100}; // K
      6'd11: lp = {3'd4, 5'b01000}; // L
      6'd12: lp = {3'd2, 5'b11000}; // M
      6'd13: lp = {3'd2, 5'b10000}; // N
      6'd14: lp = {3'd3, 5'b11100}; // O
      6'd15: lp = {3'd4, 5'b01100}; // P
      6'd16: lp = {3'd4, 5'b11010}; // Q
      6'd17: lp = {3'd3, 5'b01000}; // R
      6'd18: lp = {3'd3, 5'b00000}; // S
      6'd19: lp = {3'd1, 5'b10000}; // T
      6'd20: lp = {3'd3, 5'b00100}; // U
      6'd21: lp = {3'd4, 5'b00010}; // V
      6'd22: lp = {3'd3, 5'b01100}; // W
      6'd23: lp = {3'd4, 5'b10010}; // X
      6'd24: lp = {3'd4, 5'b10110}; // Y
      6'd25: lp = {3'd4, 5'b11000}; // Z
      6'd26: lp = {3'd5, 5'b11111}; // 0
      6'd27: lp = {3'd5, 5'b01111}; // 1
      6'd28: lp = {3'd5, 5'b00111}; // 2
      6'd29: lp = {3'd5, 5'b00011}; // 3
      6'd30: lp = {3'd5, 5'b00001}; // 4
      6'd31: lp = {3'd5, 5'b00000}; // 5
      6'd32: lp = {3'd5, 5'b10000}; // 6
      6'd33: lp = {3'd5, 5'b11000}; // 7
      6'd34: lp = {3'd5, 5'b11100}; // 8
      6'd35: lp = {3'd5, 5'b11110}; // 9
      default: lp = '0;
    endcase
  end

  always_comb begin
    sym_o.valid = (code_i < CODE_SPACE);
    sym_o.len   = lp[7:5];
    sym_o.pat   = lp[4:0];
  end

endmodule

// File: rtl/morse_code_tx.sv
// Morse transmitter: one character per valid/ready handshake onto a keyed line,
// with one-cycle element/gap event pulses for loopback against the decoder.
module morse_code_tx
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 6_000_000,
  parameter int unsigned CNT_W       = $clog2(UNIT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       dot_done,
  output logic       dash_done,
  output logic       lg_done,
  output logic       wg_done,
  output logic       bad_char
);

  morse_sym_t       sym;
  state_t           state_q;
  logic [CNT_W-1:0] cyc_q;
  logic [2:0]       unit_q;
  logic [2:0]       len_q;
  logic [4:0]       pat_q;
  logic [2:0]       unit_tgt;
  logic             cyc_last;
  logic             state_end;
  logic             key_q, busy_q, dot_q, dash_q, lg_q, wg_q, bad_q;

  morse_code_rom u_rom (
    .code_i (char_in),
    .sym_o  (sym)
  );

  always_comb begin
    unit_tgt = DOT_U;
    case (state_q)
      ST_MARK:  unit_tgt = pat_q[4] ? DASH_U : DOT_U;
      ST_SPACE: unit_tgt = GAP_U;
      ST_LGAP:  unit_tgt = LG_U;
      ST_WSP:   unit_tgt = WSP_U;
      default:  unit_tgt = DOT_U;
    endcase
  end

  assign cyc_last  = (cyc_q == CNT_W'(UNIT_CYCLES - 1));
  assign state_end = cyc_last && (unit_q == unit_tgt - 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      lg_q    <= 1'b0;
      wg_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      dot_q  <= 1'b0;
      dash_q <= 1'b0;
      lg_q   <= 1'b0;
      wg_q   <= 1'b0;
      bad_q  <= 1'b0;

      if (state_q == ST_IDLE || state_end) begin
        cyc_q  <= '0;
        unit_q <= '0;
      end else if (cyc_last) begin
        cyc_q  <= '0;
        unit_q <= unit_q + 3'd1;
      end else begin
        cyc_q  <= cyc_q + CNT_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (char_valid) begin
            if (char_in == CODE_SPACE) begin
              state_q <= ST_WSP;
              busy_q  <= 1'b1;
            end else if (sym.valid) begin
              state_q <= ST_MARK;
              busy_q  <= 1'b1;
              key_q   <= 1'b1;
              len_q   <= sym.len;
              pat_q   <= sym.pat;
            end else begin
              bad_q   <= 1'b1;
            end
          end
        end
        ST_MARK: begin
          if (state_end) begin
            key_q  <= 1'b0;
            dot_q  <= ~pat_q[4];
            dash_q <= pat_q[4];
            // Consume the element just sent; the next one moves into the MSB.
            if (len_q > 3'd1) begin
              state_q <= ST_SPACE;
              len_q   <= len_q - 3'd1;
              pat_q   <= {pat_q[3:0], 1'b0};
            end else begin
              state_q <= ST_LGAP;
            end
          end
        end
        ST_SPACE: begin
          if (state_end) begin
            state_q <= ST_MARK;
            key_q   <= 1'b1;
          end
        end
        ST_LGAP: begin
          if (state_end) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            lg_q    <= 1'b1;
          end
        end
        ST_WSP: begin
          if (state_end) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            wg_q    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign char_ready = (state_q == ST_IDLE) & ~reset;
  assign key_out    = key_q;
  assign busy       = busy_q;
  assign dot_done   = dot_q;
  assign dash_done  = dash_q;
  assign lg_done    = lg_q;
  assign wg_done    = wg_q;
  assign bad_char   = bad_q;

endmodule

// File: tb/tb_morse_code_tx.sv
// Directed bench for morse_code_tx with UNIT_CYCLES = 4.
module tb_morse_code_tx;

  localparam int unsigned U = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] char_in;
  logic       char_valid;
  logic       char_ready, key_out, busy;
  logic       dot_done, dash_done, lg_done, wg_done, bad_char;

  morse_code_tx #(.UNIT_CYCLES(U)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .key_out    (key_out),
    .busy       (busy),
    .dot_done   (dot_done),
    .dash_done  (dash_done),
    .lg_done    (lg_done),
    .wg_done    (wg_done),
    .bad_char   (bad_char)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int   runs[$];
  int   busy_cyc, n_dot, n_dash, n_lg, n_wg, n_bad;
  int   dot_at, dash_at, lg_at;
  logic key_first, key_idle, ready_end;

  function automatic int run_at(input int i);
    return (i < runs.size()) ? runs[i] : -1;
  endfunction

  // Handshake one code, then sample every negedge until busy drops
  // (the first idle sample is included so lg/wg/bad pulses are seen).
  task automatic xmit(input logic [5:0] code, input int limit);
    int   cyc;
    logic last_key;
    runs.delete();
    busy_cyc = 0; n_dot = 0; n_dash = 0; n_lg = 0; n_wg = 0; n_bad = 0;
    dot_at = -1; dash_at = -1; lg_at = -1;
    key_first = 1'b0; key_idle = 1'b1; ready_end = 1'b0; last_key = 1'b0;
    @(negedge clk);
    check_val("ready_before", int'(char_ready), 1);
    char_in    = code;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    char_in    = 6'd42;
    cyc = 1;
    forever begin
      if (dot_done)  begin n_dot++;  if (dot_at  < 0) dot_at  = cyc; end
      if (dash_done) begin n_dash++; if (dash_at < 0) dash_at = cyc; end
      if (lg_done)   begin n_lg++;   if (lg_at   < 0) lg_at   = cyc; end
      if (wg_done)   n_wg++;
      if (bad_char)  n_bad++;
      if (busy) begin
        busy_cyc++;
        if (runs.size() == 0) begin
          key_first = key_out;
          runs.push_back(1);
        end else if (key_out !== last_key) begin
          runs.push_back(1);
        end else begin
          runs[runs.size()-1] = runs[runs.size()-1] + 1;
        end
        last_key = key_out;
      end else begin
        key_idle  = key_out;
        ready_end = char_ready;
        break;
      end
      if (cyc >= limit) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    reset      = 1'b1;
    char_valid = 1'b0;
    char_in    = '0;
    repeat (2) @(negedge clk);
    check_val("rst_key",    int'(key_out), 0);
    check_val("rst_busy",   int'(busy), 0);
    check_val("rst_ready",  int'(char_ready), 0);
    check_val("rst_pulses", int'({dot_done, dash_done, lg_done, wg_done, bad_char}), 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst", int'(char_ready), 1);

    // 'E' = .
    xmit(6'd4, 300);
    check_val("E_busy",  busy_cyc, 16);
    check_val("E_nrun",  runs.size(), 2);
    check_val("E_first", int'(key_first), 1);
    check_val("E_run0",  run_at(0), 4);
    check_val("E_run1",  run_at(1), 12);
    check_val("E_dot",   n_dot, 1);
    check_val("E_dash",  n_dash, 0);
    check_val("E_lg_at", lg_at, 17);
    check_val("E_ready", int'(ready_end), 1);

    // 'A' = .-
    xmit(6'd0, 300);
    check_val("A_busy",    busy_cyc, 32);
    check_val("A_nrun",    runs.size(), 4);
    check_val("A_run0",    run_at(0), 4);
    check_val("A_run1",    run_at(1), 4);
    check_val("A_run2",    run_at(2), 12);
    check_val("A_run3",    run_at(3), 12);
    check_val("A_dot_at",  dot_at, 5);
    check_val("A_dash_at", dash_at, 21);
    check_val("A_lg_at",   lg_at, 33);
    check_val("A_counts",  n_dot * 100 + n_dash * 10 + n_lg, 111);

    // '0' = -----
    xmit(6'd26, 300);
    check_val("D0_busy", busy_cyc, 88);
    check_val("D0_nrun", runs.size(), 10);
    check_val("D0_run0", run_at(0), 12);
    check_val("D0_run1", run_at(1), 4);
    check_val("D0_run8", run_at(8), 12);
    check_val("D0_run9", run_at(9), 12);
    check_val("D0_dash", n_dash, 5);
    check_val("D0_dot",  n_dot, 0);

    // 'Q' = --.-
    xmit(6'd16, 300);
    check_val("Q_busy", busy_cyc, 64);
    check_val("Q_nrun", runs.size(), 8);
    check_val("Q_run4", run_at(4), 4);
    check_val("Q_run6", run_at(6), 12);
    check_val("Q_dot",  n_dot, 1);
    check_val("Q_dash", n_dash, 3);

    // '9' = ----. (last valid code)
    xmit(6'd35, 300);
    check_val("D9_busy", busy_cyc, 80);
    check_val("D9_run8", run_at(8), 4);
    check_val("D9_dot",  n_dot, 1);
    check_val("D9_dash", n_dash, 4);

    // invalid codes
    xmit(6'd40, 10);
    check_val("bad40_busy",  busy_cyc, 0);
    check_val("bad40_pulse", n_bad, 1);
    check_val("bad40_key",   int'(key_idle), 0);
    check_val("bad40_ready", int'(ready_end), 1);
    @(negedge clk);
    check_val("bad40_single", int'(bad_char), 0);
    xmit(6'd63, 10);
    check_val("bad63_pulse", n_bad, 1);
    check_val("bad63_busy",  busy_cyc, 0);

    // 'T' then word space with char_valid held; char_in switches while busy
    @(negedge clk);
    check_val("TS_ready", int'(char_ready), 1);
    char_in    = 6'd19;
    char_valid = 1'b1;
    @(negedge clk);
    char_in = 6'd36;
    for (int c = 1; c <= 45; c++) begin
      logic [4:0] exp_v;
      exp_v[4] = (c <= 12);
      exp_v[3] = (c <= 24) || (c >= 26 && c <= 41);
      exp_v[2] = (c == 13);
      exp_v[1] = (c == 25);
      exp_v[0] = (c == 42);
      check_val($sformatf("TS_c%0d", c),
                int'({key_out, busy, dash_done, lg_done, wg_done}), int'(exp_v));
      if (c == 26) char_valid = 1'b0;
      @(negedge clk);
    end

    // reset in the middle of a 'T' dash
    char_in    = 6'd19;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_val("RST_key_pre", int'(key_out), 1);
    #2 reset = 1'b1;
    #1;
    check_val("RST_key_async", int'(key_out), 0);
    check_val("RST_busy",      int'(busy), 0);
    check_val("RST_ready",     int'(char_ready), 0);
    begin
      int nd = 0;
      repeat (3) begin
        @(negedge clk);
        if (dash_done || dot_done || lg_done) nd++;
      end
      reset = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (dash_done || dot_done || lg_done) nd++;
      end
      check_val("RST_no_pulse", nd, 0);
    end
    xmit(6'd4, 300);
    check_val("RE_busy", busy_cyc, 16);
    check_val("RE_run0", run_at(0), 4);
    check_val("RE_run1", run_at(1), 12);
    check_val("RE_dot",  n_dot, 1);
    check_val("RE_dash", n_dash, 0);
    check_val("RE_lg",   n_lg, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_code_tx.md
Name: morse_code_tx

Overview:
- Morse transmitter: the encode direction of the existing Morse keying path.
- Accepts one character code per valid/ready handshake and drives a single keyed line, `key_out`.
- Timing is in units of `UNIT_CYCLES` clocks: dot 1, dash 3, intra-character gap 1, letter gap 3, word gap 7 total.
- Emits one-cycle event pulses (dot/dash/letter gap/word gap) so it can be looped back against the Morse decoder FSM.

Parameters:
- `UNIT_CYCLES`, default 6_000_000: clocks per Morse unit (60 ms at 100 MHz, about 20 WPM). Minimum 1. Benches use 4.
- `CNT_W`, default $clog2(UNIT_CYCLES+1): width of the cycle counter. Derived; do not override.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `char_in`  in  6  character code: 0-25 = A-Z; 26-35 = digits 0-9; 36 = word space; 37-63 invalid.
- `char_valid`  in  1  `char_in` is valid.
- `char_ready`  out  1  block can accept a character.
- `key_out`  out  1  keyed line; 1 = tone/mark.
- `busy`  out  1  high in any state other than IDLE.
- `dot_done`  out  1  one-cycle pulse at the end of a dot mark.
- `dash_done`  out  1  one-cycle pulse at the end of a dash mark.
- `lg_done`  out  1  one-cycle pulse at the end of a letter gap.
- `wg_done`  out  1  one-cycle pulse at the end of the word-space extension.
- `bad_char`  out  1  one-cycle pulse when an invalid code is accepted.

Behaviour:
- Reset values: state IDLE; `key_out`, `busy` and all pulses 0. `char_ready` = (state==IDLE) & ~reset, so it is 0 while reset is high.
- Handshake:
  - A transfer occurs on a rising edge with `char_valid` & `char_ready`.
  - `char_in` is sampled only on that edge.
  - `char_ready` is low from the cycle after acceptance until the block returns to IDLE.
- Lookup: the code maps to a length (1-5) and an element pattern (5 bits, first element in MSB, 1 = dash), latched at acceptance.
- States:
  - IDLE: on acceptance of a valid letter/digit go to MARK. On code 36 go to WSP. On codes 37-63 stay in IDLE, pulse `bad_char` next cycle, `char_ready` high again next cycle.
  - MARK: `key_out`=1 for 1 unit (dot) or 3 units (dash). On exit pulse `dot_done`/`dash_done`. Then go to SPACE if elements remain, else to LGAP.
  - SPACE: `key_out`=0 for 1 unit, then MARK with the next element.
  - LGAP: `key_out`=0 for 3 units, pulse `lg_done`, go to IDLE.
  - WSP: `key_out`=0 for 4 units (which adds to the preceding LGAP to make 7), pulse `wg_done`, go to IDLE.
- Timing:
  - Every state duration is exactly n×`UNIT_CYCLES` clocks.
  - The cycle counter and unit counter clear on each state entry.
  - `key_out` is registered: it rises on the edge that accepts the character, so it is visible the cycle after the handshake.
- Done pulses are asserted in the first cycle of the following state; they are registered.
- Back-to-back: with `char_valid` held high, the next character is accepted in the first IDLE cycle. No extra gap is inserted beyond LGAP.
- Reset mid-operation: `key_out` drops asynchronously, the character in flight is discarded, no pulses are emitted, and the block restarts in IDLE.
- `char_in` changing while not ready is ignored.

Decomposition:
- Shared package `morse_pkg` holds:
  - state encoding localparams;
  - code constants `CODE_SPACE`=36, `CODE_MAX`=36;
  - unit multipliers `DOT_U`=1, `DASH_U`=3, `GAP_U`=1, `LG_U`=3, `WSP_U`=4.
- Sub-module `morse_code_rom`: combinational 6-bit code to {valid, len[2:0], pat[4:0]} lookup, reusable by a future decoder-to-ASCII stage.

Test Plan:
- 'E' (4), U=4 -> `key_out` high for exactly 4 cycles starting the cycle after the handshake; `dot_done` pulse; low 12 cycles; `lg_done`; `char_ready` high 16 cycles after acceptance.
- 'A' (0) -> pattern high 4 / low 4 / high 12 / low 12 cycles; one `dot_done` then one `dash_done`, then `lg_done`; `busy` for 32 cycles.
- '0' (26) -> five 12-cycle marks separated by 4-cycle spaces, then 12-cycle LGAP; 88 busy cycles; 5 `dash_done`.
- 'T' (19) then space (36) back-to-back with `char_valid` held -> high 12, low 12, `lg_done`; then low 16, `wg_done`; total low 28 = 7 units.
- Invalid 40 -> accepted in one cycle; `bad_char` pulses once; `key_out` stays 0; `char_ready` high the next cycle.
- Reset asserted mid-dash of 'T' -> `key_out` 0 in the same cycle with no clock edge; no `dash_done`; after release, 'E' transmits with nominal timing.
